// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle RV32 control sequencer stepping LUI/LW/SW over a shared bus
module ctrl_seq #(
    parameter int WIDTH           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] bus,
    inout  wire  [WIDTH-1:0] addr,
    output logic [4:0]       reg_idx,
    output logic             reg_en,
    output logic             reg_write,
    output logic             pc_en,
    output logic             pc_inc,
    output logic             mem_read,
    output logic             mem_write,
    output logic             halted,
    output logic [WIDTH-1:0] ir_out
);
    localparam logic [2:0] FETCH   = 3'd0;
    localparam logic [2:0] DECODE  = 3'd1;
    localparam logic [2:0] LUI_WB  = 3'd2;
    localparam logic [2:0] LD_ADDR = 3'd3;
    localparam logic [2:0] ST_ADDR = 3'd4;
    localparam logic [2:0] LD_MEM  = 3'd5;
    localparam logic [2:0] ST_MEM  = 3'd6;
    localparam logic [2:0] HALT    = 3'd7;

    logic [2:0]       state, next;
    logic [WIDTH-1:0] ir, ea, imm;
    logic [4:0]       rd, rs1, rs2;
    logic             live, is_lui, is_lw, is_sw, wb_state, addr_state, mem_state;

    assign rd         = ir[11:7];
    assign rs1        = ir[19:15];
    assign rs2        = ir[24:20];
    assign is_lui     = ir[6:0] == 7'h37;
    assign is_lw      = ir[6:0] == 7'h03 && ir[14:12] == 3'b010;
    assign is_sw      = ir[6:0] == 7'h23 && ir[14:12] == 3'b010;
    assign wb_state   = state == LUI_WB || state == LD_MEM;
    assign addr_state = state == LD_ADDR || state == ST_ADDR;
    assign mem_state  = state == LD_MEM || state == ST_MEM;
    assign imm        = state == ST_ADDR ? {{(WIDTH-12){ir[31]}}, ir[31:25], ir[11:7]}
                                         : {{(WIDTH-12){ir[31]}}, ir[31:20]};

    always_comb begin
        case (state)
            FETCH:   next = DECODE;
            DECODE:  next = is_lui ? LUI_WB : is_lw ? LD_ADDR : is_sw ? ST_ADDR
                          : HALT_ON_ILLEGAL ? HALT : FETCH;
            LD_ADDR: next = LD_MEM;
            ST_ADDR: next = ST_MEM;
            HALT:    next = HALT;
            default: next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            ir    <= '0;
            ea    <= '0;
        end else begin
            state <= next;
            if (state == FETCH) ir <= bus;
            if (addr_state) ea <= bus + imm;
        end
    end

    // Every strobe is gated by rst so a reset cycle can never leave a partial write behind.
    assign live      = !rst;
    assign pc_en     = live && state == FETCH;
    assign pc_inc    = live && state == DECODE;
    assign mem_read  = live && (state == FETCH || state == LD_MEM);
    assign mem_write = live && state == ST_MEM;
    assign halted    = live && state == HALT;
    assign reg_en    = live && (wb_state || addr_state || state == ST_MEM);
    assign reg_write = live && wb_state && rd != 5'd0;
    assign reg_idx   = !live ? 5'd0 : addr_state ? rs1 : state == ST_MEM ? rs2 : wb_state ? rd : 5'd0;
    assign bus       = live && state == LUI_WB ? {ir[WIDTH-1:12], 12'b0} : 'z;
    assign addr      = live && mem_state ? ea : 'z;
    assign ir_out    = ir;
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed scenario bench for ctrl_seq with hand-computed expectations
module tb_ctrl_seq;
    logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
    always #5 clk = ~clk;

    wire  [31:0] bus, addr, bus2, addr2;
    logic        b_en = 1'b0, a_en = 1'b0, b2_en = 1'b0;
    logic [31:0] b_val = '0, a_val = '0, b2_val = '0;
    assign bus  = b_en ? b_val : 'z;
    assign addr = a_en ? a_val : 'z;
    assign bus2 = b2_en ? b2_val : 'z;

    logic [4:0]  reg_idx, n_reg_idx;
    logic        reg_en, reg_write, pc_en, pc_inc, mem_read, mem_write, halted;
    logic        n_reg_en, n_reg_write, n_pc_en, n_pc_inc, n_mem_read, n_mem_write, n_halted;
    logic [31:0] ir_out, n_ir_out;
    logic [6:0]  st, n_st;
    assign st   = {pc_en, pc_inc, mem_read, mem_write, reg_en, reg_write, halted};
    assign n_st = {n_pc_en, n_pc_inc, n_mem_read, n_mem_write, n_reg_en, n_reg_write, n_halted};

    int tests = 0, fails = 0;

    ctrl_seq #(.WIDTH(32), .HALT_ON_ILLEGAL(1'b1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .addr(addr), .reg_idx(reg_idx), .reg_en(reg_en),
        .reg_write(reg_write), .pc_en(pc_en), .pc_inc(pc_inc), .mem_read(mem_read),
        .mem_write(mem_write), .halted(halted), .ir_out(ir_out)
    );

    ctrl_seq #(.WIDTH(32), .HALT_ON_ILLEGAL(1'b0)) u_nop (
        .clk(clk), .rst(rst2), .bus(bus2), .addr(addr2), .reg_idx(n_reg_idx), .reg_en(n_reg_en),
        .reg_write(n_reg_write), .pc_en(n_pc_en), .pc_inc(n_pc_inc), .mem_read(n_mem_read),
        .mem_write(n_mem_write), .halted(n_halted), .ir_out(n_ir_out)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] v);
        b_en  = 1'b1;
        b_val = v;
    endtask

    task automatic rel;
        b_en = 1'b0;
    endtask

    task automatic test_reset;
        drv(32'h0);
        a_en  = 1'b1;
        a_val = 32'h0;
        @(negedge clk);
        tests++; if (st !== 7'b0) begin fails++; $display("FAIL reset_strobes got %b want %b", st, 7'b0); end
        tests++; if (bus !== 32'h0) begin fails++; $display("FAIL reset_bus got %h want %h", bus, 32'h0); end
        tests++; if (addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want %h", addr, 32'h0); end
        step;
        @(negedge clk);
        tests++; if (ir_out !== 32'h0) begin fails++; $display("FAIL reset_ir got %h want %h", ir_out, 32'h0); end
        step;
        rst  = 1'b0;
        a_en = 1'b0;
        rel;
        @(negedge clk);
        tests++; if (st !== 7'b1010000) begin fails++; $display("FAIL reset_fetch got %b want %b", st, 7'b1010000); end
    endtask

    task automatic test_lui;
        drv(32'h123452B7);
        step;
        drv(32'h0);
        @(negedge clk);
        tests++; if (st !== 7'b0100000) begin fails++; $display("FAIL lui_decode got %b want %b", st, 7'b0100000); end
        tests++; if (bus !== 32'h0) begin fails++; $display("FAIL lui_decode_bus got %h want %h", bus, 32'h0); end
        step;
        rel;
        @(negedge clk);
        tests++; if (bus !== 32'h12345000) begin fails++; $display("FAIL lui_bus got %h want %h", bus, 32'h12345000); end
        tests++; if (reg_idx !== 5'd5) begin fails++; $display("FAIL lui_idx got %0d want %0d", reg_idx, 5); end
        tests++; if (st !== 7'b0000110) begin fails++; $display("FAIL lui_wb got %b want %b", st, 7'b0000110); end
        step;
        @(negedge clk);
        tests++; if (st !== 7'b1010000) begin fails++; $display("FAIL lui_refetch got %b want %b", st, 7'b1010000); end
        tests++; if (ir_out !== 32'h123452B7) begin fails++; $display("FAIL lui_ir got %h want %h", ir_out, 32'h123452B7); end
    endtask

    task automatic test_lw;
        drv(32'h0082A303);
        step;
        rel;
        @(negedge clk);
        tests++; if (st !== 7'b0100000) begin fails++; $display("FAIL lw_decode got %b want %b", st, 7'b0100000); end
        step;
        drv(32'h100);
        a_en  = 1'b1;
        a_val = 32'h0;
        @(negedge clk);
        tests++; if (reg_idx !== 5'd5) begin fails++; $display("FAIL lw_addr_idx got %0d want %0d", reg_idx, 5); end
        tests++; if (st !== 7'b0000100) begin fails++; $display("FAIL lw_addr got %b want %b", st, 7'b0000100); end
        tests++; if (addr !== 32'h0) begin fails++; $display("FAIL lw_addr_bus got %h want %h", addr, 32'h0); end
        step;
        drv(32'h0BADF00D);
        a_en = 1'b0;
        @(negedge clk);
        tests++; if (addr !== 32'h108) begin fails++; $display("FAIL lw_ea got %h want %h", addr, 32'h108); end
        tests++; if (reg_idx !== 5'd6) begin fails++; $display("FAIL lw_mem_idx got %0d want %0d", reg_idx, 6); end
        tests++; if (st !== 7'b0010110) begin fails++; $display("FAIL lw_mem got %b want %b", st, 7'b0010110); end
        step;
        rel;
        @(negedge clk);
        tests++; if (st !== 7'b1010000) begin fails++; $display("FAIL lw_refetch got %b want %b", st, 7'b1010000); end
    endtask

    task automatic test_sw;
        drv(32'h0062A223);
        step;
        rel;
        @(negedge clk);
        tests++; if (st !== 7'b0100000) begin fails++; $display("FAIL sw_decode got %b want %b", st, 7'b0100000); end
        step;
        drv(32'h100);
        @(negedge clk);
        tests++; if (reg_idx !== 5'd5) begin fails++; $display("FAIL sw_addr_idx got %0d want %0d", reg_idx, 5); end
        tests++; if (st !== 7'b0000100) begin fails++; $display("FAIL sw_addr got %b want %b", st, 7'b0000100); end
        step;
        drv(32'hCAFEF00D);
        @(negedge clk);
        tests++; if (addr !== 32'h104) begin fails++; $display("FAIL sw_ea got %h want %h", addr, 32'h104); end
        tests++; if (reg_idx !== 5'd6) begin fails++; $display("FAIL sw_mem_idx got %0d want %0d", reg_idx, 6); end
        tests++; if (st !== 7'b0001100) begin fails++; $display("FAIL sw_mem got %b want %b", st, 7'b0001100); end
        tests++; if (bus !== 32'hCAFEF00D) begin fails++; $display("FAIL sw_bus got %h want %h", bus, 32'hCAFEF00D); end
        step;
        rel;
        @(negedge clk);
        tests++; if (st !== 7'b1010000) begin fails++; $display("FAIL sw_refetch got %b want %b", st, 7'b1010000); end
    endtask

    task automatic test_wrap_x0;
        drv(32'hFFC2A303);
        step;
        rel;
        step;
        drv(32'h0);
        step;
        drv(32'h0);
        @(negedge clk);
        tests++; if (addr !== 32'hFFFFFFFC) begin fails++; $display("FAIL wrap_ea got %h want %h", addr, 32'hFFFFFFFC); end
        step;
        drv(32'hABCDE037);
        @(negedge clk);
        tests++; if (st !== 7'b1010000) begin fails++; $display("FAIL wrap_refetch got %b want %b", st, 7'b1010000); end
        step;
        rel;
        step;
        @(negedge clk);
        tests++; if (st !== 7'b0000100) begin fails++; $display("FAIL x0_wb got %b want %b", st, 7'b0000100); end
        tests++; if (bus !== 32'hABCDE000) begin fails++; $display("FAIL x0_bus got %h want %h", bus, 32'hABCDE000); end
        step;
        @(negedge clk);
        tests++; if (st !== 7'b1010000) begin fails++; $display("FAIL x0_refetch got %b want %b", st, 7'b1010000); end
    endtask

    task automatic test_halt;
        drv(32'h0);
        step;
        @(negedge clk);
        tests++; if (st !== 7'b0100000) begin fails++; $display("FAIL halt_decode got %b want %b", st, 7'b0100000); end
        step;
        @(negedge clk);
        tests++; if (st !== 7'b0000001) begin fails++; $display("FAIL halt_enter got %b want %b", st, 7'b0000001); end
        for (int i = 0; i < 20; i++) begin
            step;
            @(negedge clk);
            tests++;
            if (st !== 7'b0000001 || bus !== 32'h0) begin
                fails++;
                $display("FAIL halt_hold cycle %0d got %b/%h want %b/%h", i, st, bus, 7'b0000001, 32'h0);
            end
        end
    endtask

    task automatic test_nop;
        step;
        rst2   = 1'b0;
        b2_en  = 1'b1;
        b2_val = 32'h0;
        @(negedge clk);
        tests++; if (n_st !== 7'b1010000) begin fails++; $display("FAIL nop_fetch got %b want %b", n_st, 7'b1010000); end
        step;
        b2_en = 1'b0;
        @(negedge clk);
        tests++; if (n_st !== 7'b0100000) begin fails++; $display("FAIL nop_decode got %b want %b", n_st, 7'b0100000); end
        step;
        @(negedge clk);
        tests++; if (n_st !== 7'b1010000) begin fails++; $display("FAIL nop_refetch got %b want %b", n_st, 7'b1010000); end
        rst2 = 1'b1;
    endtask

    task automatic test_reset_mid;
        rel;
        rst = 1'b1;
        step;
        rst = 1'b0;
        @(negedge clk);
        tests++; if (st !== 7'b1010000) begin fails++; $display("FAIL mid_fetch got %b want %b", st, 7'b1010000); end
        drv(32'h0082A303);
        step;
        rel;
        step;
        drv(32'h100);
        step;
        drv(32'h55);
        @(negedge clk);
        tests++; if (st !== 7'b0010110) begin fails++; $display("FAIL mid_ldmem got %b want %b", st, 7'b0010110); end
        rst = 1'b1;
        #1;
        tests++; if (st !== 7'b0) begin fails++; $display("FAIL mid_gated got %b want %b", st, 7'b0); end
        step;
        rel;
        @(negedge clk);
        tests++; if (reg_write !== 1'b0 || mem_read !== 1'b0) begin fails++; $display("FAIL mid_abort got %b%b want 00", reg_write, mem_read); end
        tests++; if (ir_out !== 32'h0) begin fails++; $display("FAIL mid_ir got %h want %h", ir_out, 32'h0); end
        step;
        rst = 1'b0;
        @(negedge clk);
        tests++; if (st !== 7'b1010000) begin fails++; $display("FAIL mid_refetch got %b want %b", st, 7'b1010000); end
        drv(32'h123452B7);
        step;
        rel;
        step;
        @(negedge clk);
        tests++; if (bus !== 32'h12345000 || reg_idx !== 5'd5 || st !== 7'b0000110) begin
            fails++;
            $display("FAIL mid_lui got %h/%0d/%b want %h/%0d/%b", bus, reg_idx, st, 32'h12345000, 5, 7'b0000110);
        end
    endtask

    initial begin
        test_reset;
        test_lui;
        test_lw;
        test_sw;
        test_wrap_x0;
        test_halt;
        test_nop;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
